syscall_controller: RTL and testbench

- Sequences the 5-stage pipeline around a SYSCALL held in decode.
- On detection it freezes fetch/decode and injects bubbles into execute until E/M/W have drained and all older register writes have retired.
- It then samples the now-current syscall parameter and hands the call to an external service agent over a req/ack handshake, or halts the core on exit.
- Sits beside the hazard unit; its stall_f/stall_d/flush_e are OR-ed into the hazard unit's StallF/StallD/FlushE.

---
 rtl/syscall_controller.sv | 205 ++++++++++++++++++++
 tb/tb_syscall_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_controller.sv
// syscall_controller
//
// Sequences the 5-stage pipeline around a SYSCALL sitting in decode. When one
// is seen, fetch/decode are frozen and bubbles are injected into execute for
// DRAIN_CYCLES cycles so that E/M/W drain and all older register writes
// retire. The argument is then re-sampled from decode and the call is handed
// to an external service agent over a req/ack handshake. The exit function
// code halts the core until reset instead.
//
// Optional feature macro: SYSCALL_TIMEOUT_EN
//   Defined   : REQ is abandoned after TIMEOUT_CYCLES cycles without ack and
//               svc_error pulses for that one cycle.
//   Undefined : svc_error is tied low and REQ waits for svc_ack forever.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous, active-high
//   syscall_d        in   decode-stage instruction is SYSCALL
//   syscall_funct_d  in   [31:0] function code ($v0 read in decode)
//   syscall_param1_d in   [31:0] first argument ($a0 read in decode)
//   svc_ack          in   service agent has completed the call
//   stall_f          out  hold PC (combinational)
//   stall_d          out  hold fetch/decode register (combinational)
//   flush_e          out  bubble into execute register (combinational)
//   svc_req          out  service request (registered)
//   svc_funct        out  [31:0] latched function code
//   svc_param        out  [31:0] latched argument
//   busy             out  controller is not idle (combinational)
//   halted           out  sticky exit indication (registered)
//   svc_error        out  watchdog expiry pulse (combinational)

module syscall_controller #(
  parameter int unsigned DRAIN_CYCLES   = 3,
  parameter logic [31:0] EXIT_FUNCT     = 32'd10,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        syscall_d,
  input  logic [31:0] syscall_funct_d,
  input  logic [31:0] syscall_param1_d,
  input  logic        svc_ack,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_e,
  output logic        svc_req,
  output logic [31:0] svc_funct,
  output logic [31:0] svc_param,
  output logic        busy,
  output logic        halted,
  output logic        svc_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_REQ,
    ST_RELEASE,
    ST_HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic        svc_req_q, svc_req_d;
  logic [31:0] svc_funct_q, svc_funct_d;
  logic [31:0] svc_param_q, svc_param_d;
  logic        halted_q, halted_d;
  logic        stall_any;
  logic        error_pulse;

`ifdef SYSCALL_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_hit;

  // tmo_cnt_q counts completed REQ cycles, so the current cycle is the
  // TIMEOUT_CYCLES-th one when the count equals TIMEOUT_CYCLES-1.
  // A simultaneous ack takes priority over the timeout.
  assign tmo_hit = (state_q == ST_REQ) && !svc_ack &&
                   (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    svc_req_d   = svc_req_q;
    svc_funct_d = svc_funct_q;
    svc_param_d = svc_param_q;
    halted_d    = halted_q;
    stall_any   = 1'b0;
    error_pulse = 1'b0;
`ifdef SYSCALL_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Stall in the very cycle the SYSCALL first appears in decode.
        stall_any = syscall_d;
        if (syscall_d) begin
          svc_funct_d = syscall_funct_d;
          drain_cnt_d = 4'(DRAIN_CYCLES);
          state_d     = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        stall_any   = 1'b1;
        drain_cnt_d = drain_cnt_q - 4'd1;
        if (drain_cnt_q == 4'd1) begin
          // Older writes have now retired, so the register file value read
          // in decode this cycle is the architecturally correct argument.
          svc_param_d = syscall_param1_d;
          if (svc_funct_q == EXIT_FUNCT) begin
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end else begin
            svc_req_d = 1'b1;
            state_d   = ST_REQ;
`ifdef SYSCALL_TIMEOUT_EN
            tmo_cnt_d = 16'd0;
`endif
          end
        end
      end

      ST_REQ: begin
        stall_any = 1'b1;
`ifdef SYSCALL_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
        if (svc_ack) begin
          svc_req_d = 1'b0;
          state_d   = ST_RELEASE;
        end
`ifdef SYSCALL_TIMEOUT_EN
        else if (tmo_hit) begin
          svc_req_d   = 1'b0;
          error_pulse = 1'b1;
          state_d     = ST_RELEASE;
        end
`endif
      end

      // One cycle with stalls low lets the serviced SYSCALL leave decode;
      // syscall_d is still high here but belongs to the same instruction.
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      ST_HALTED: begin
        stall_any = 1'b1;
        svc_req_d = 1'b0;
        halted_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= 4'd0;
      svc_req_q   <= 1'b0;
      svc_funct_q <= 32'd0;
      svc_param_q <= 32'd0;
      halted_q    <= 1'b0;
`ifdef SYSCALL_TIMEOUT_EN
      tmo_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      svc_req_q   <= svc_req_d;
      svc_funct_q <= svc_funct_d;
      svc_param_q <= svc_param_d;
      halted_q    <= halted_d;
`ifdef SYSCALL_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  // Combinational outputs are gated off while reset is asserted.
  assign stall_f   = !reset && stall_any;
  assign stall_d   = !reset && stall_any;
  assign flush_e   = !reset && stall_any;
  assign busy      = !reset && (state_q != ST_IDLE);
  assign svc_req   = svc_req_q;
  assign svc_funct = svc_funct_q;
  assign svc_param = svc_param_q;
  assign halted    = halted_q;

`ifdef SYSCALL_TIMEOUT_EN
  assign svc_error = !reset && error_pulse;
`else
  assign svc_error = 1'b0;
  // error_pulse is never raised without the watchdog.
  logic unused_error;
  assign unused_error = error_pulse;
`endif

endmodule

// File: tb/tb_syscall_controller.sv
// Testbench for syscall_controller: directed walk through the main scenarios
// followed by randomized stimulus, all outputs compared each cycle against a
// transaction-level reference model.

module tb_syscall_controller;

  localparam int          DRAIN = 3;
  localparam logic [31:0] EXITF = 32'd10;
  localparam int          TMO   = 8;
`ifdef SYSCALL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        syscall_d;
  logic [31:0] syscall_funct_d;
  logic [31:0] syscall_param1_d;
  logic        svc_ack;
  logic        stall_f, stall_d, flush_e, svc_req, busy, halted, svc_error;
  logic [31:0] svc_funct, svc_param;

  syscall_controller #(
    .DRAIN_CYCLES  (DRAIN),
    .EXIT_FUNCT    (EXITF),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .syscall_d       (syscall_d),
    .syscall_funct_d (syscall_funct_d),
    .syscall_param1_d(syscall_param1_d),
    .svc_ack         (svc_ack),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .flush_e         (flush_e),
    .svc_req         (svc_req),
    .svc_funct       (svc_funct),
    .svc_param       (svc_param),
    .busy            (busy),
    .halted          (halted),
    .svc_error       (svc_error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: tracks the call in progress in terms of how many drain
  // cycles remain, whether a request is outstanding, how long it has been
  // outstanding, and whether the post-call release cycle is pending.
  int          m_wait = 0;
  bit          m_req  = 0;
  int          m_age  = 0;
  bit          m_rel  = 0;
  bit          m_halt = 0;
  logic [31:0] m_funct = '0;
  logic [31:0] m_param = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Compare every output against the model in the middle of the cycle.
  task automatic sample();
    bit idle, stall_e, err_e;
    #4;
    idle    = !(m_wait > 0 || m_req || m_rel || m_halt);
    stall_e = !reset && ((idle && syscall_d) || m_wait > 0 || m_req || m_halt);
    err_e   = TMO_EN && !reset && m_req && !svc_ack && (m_age + 1 == TMO);
    chk("stall_f", {31'd0, stall_f}, {31'd0, stall_e});
    chk("stall_d", {31'd0, stall_d}, {31'd0, stall_e});
    chk("flush_e", {31'd0, flush_e}, {31'd0, stall_e});
    chk("busy", {31'd0, busy}, {31'd0, !reset && !idle});
    chk("svc_req", {31'd0, svc_req}, {31'd0, m_req});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("svc_error", {31'd0, svc_error}, {31'd0, err_e});
    chk("svc_funct", svc_funct, m_funct);
    chk("svc_param", svc_param, m_param);
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      m_wait = 0; m_req = 0; m_age = 0; m_rel = 0; m_halt = 0;
      m_funct = '0; m_param = '0;
    end else if (m_halt) begin
      // only reset leaves the halt
    end else if (m_rel) begin
      m_rel = 0;
    end else if (m_req) begin
      m_age++;
      if (svc_ack || (TMO_EN && m_age == TMO)) begin
        m_req = 0;
        m_rel = 1;
      end
    end else if (m_wait > 0) begin
      if (m_wait == 1) begin
        m_param = syscall_param1_d;
        if (m_funct == EXITF) m_halt = 1;
        else begin
          m_req = 1;
          m_age = 0;
        end
      end
      m_wait--;
    end else if (syscall_d) begin
      m_funct = syscall_funct_d;
      m_wait  = DRAIN;
    end
    cyc++;
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) begin
      sample();
      tick();
    end
  endtask

  task automatic set_in(input bit s, input logic [31:0] f, input logic [31:0] p, input bit a);
    syscall_d = s; syscall_funct_d = f; syscall_param1_d = p; svc_ack = a;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 32'd0, 32'd0, 0);
    tick();                 // registers still unknown before the first edge
    sample();               // reset state
    tick();
    reset = 1'b0;
    cyc   = 0;

    // 1: syscall at 10, param changes to 42 at 13, request from 14.
    run_to(10);
    set_in(1, 32'd1, 32'd5, 0);
    sample(); chk("t1_stall_c10", {31'd0, stall_f}, 32'd1); tick();
    run_to(13);
    syscall_param1_d = 32'd42;
    sample(); chk("t1_stall_c13", {31'd0, flush_e}, 32'd1); tick();
    sample();
    chk("t1_req_c14", {31'd0, svc_req}, 32'd1);
    chk("t1_funct_c14", svc_funct, 32'd1);
    chk("t1_param_c14", svc_param, 32'd42);
    tick();
    // 2: ack at 20, release at 21 with syscall_d still high, idle at 22.
    run_to(20);
    svc_ack = 1;
    sample(); tick();
    svc_ack = 0;
    sample();
    chk("t2_req_c21", {31'd0, svc_req}, 32'd0);
    chk("t2_stall_c21", {31'd0, stall_f}, 32'd0);
    chk("t2_busy_c21", {31'd0, busy}, 32'd1);
    tick();
    set_in(1, 32'd7, 32'd99, 0);
    sample(); chk("t2_busy_c22", {31'd0, busy}, 32'd0); chk("t2_stall_c22", {31'd0, stall_d}, 32'd1); tick();
    // 4: ack during drain is ignored; ack in first request cycle is accepted.
    svc_ack = 1;
    sample(); chk("t4_busy_c23", {31'd0, busy}, 32'd1); tick();
    svc_ack = 0;
    run_to(26);
    svc_ack = 1;
    sample(); chk("t4_req_c26", {31'd0, svc_req}, 32'd1); chk("t4_funct_c26", svc_funct, 32'd7); tick();
    set_in(0, 32'd0, 32'd0, 0);
    sample(); chk("t4_req_c27", {31'd0, svc_req}, 32'd0); tick();
    svc_ack = 1;            // ack while idle
    run_to(30);
    // 3: exit call halts from T+4 until reset.
    set_in(1, EXITF, 32'd3, 0);
    run_to(34);
    sample(); chk("t3_halt_c34", {31'd0, halted}, 32'd1); tick();
    svc_ack = 1;
    run_to(40);
    reset = 1;
    sample(); chk("t3_stall_rst", {31'd0, stall_f}, 32'd0); tick();
    reset = 0;
    set_in(1, 32'd3, 32'd11, 0);
    sample(); chk("t3_halt_clr", {31'd0, halted}, 32'd0); chk("t3_busy_clr", {31'd0, busy}, 32'd0); tick();
    // 5: reset during request, then a normal call.
    run_to(45);
    sample(); chk("t5_req_c45", {31'd0, svc_req}, 32'd1); tick();
    reset = 1;
    sample(); tick();
    reset = 0;
    set_in(0, 32'd0, 32'd0, 0);
    sample(); chk("t5_req_after_rst", {31'd0, svc_req}, 32'd0); chk("t5_busy_after_rst", {31'd0, busy}, 32'd0); tick();
    set_in(1, 32'd4, 32'd77, 0);
    run_to(53);
    svc_ack = 1;
    sample(); tick();
    set_in(0, 32'd0, 32'd0, 0);
    run_to(56);
`ifdef SYSCALL_TIMEOUT_EN
    // 6: watchdog expiry on the 8th request cycle, then ack racing it.
    set_in(1, 32'd5, 32'd55, 0);
    run_to(67);
    sample(); chk("t6_err_c67", {31'd0, svc_error}, 32'd1); tick();
    syscall_d = 0;
    sample(); chk("t6_req_c68", {31'd0, svc_req}, 32'd0); tick();
    run_to(70);
    set_in(1, 32'd6, 32'd66, 0);
    run_to(81);
    svc_ack = 1;
    sample(); chk("t6_err_ack", {31'd0, svc_error}, 32'd0); tick();
    set_in(0, 32'd0, 32'd0, 0);
    run_to(84);
`endif

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 99) < (m_halt ? 10 : 1));
      syscall_d        = $urandom_range(0, 1);
      syscall_funct_d  = ($urandom_range(0, 7) == 0) ? EXITF : 32'($urandom_range(0, 15));
      syscall_param1_d = $urandom;
      svc_ack          = ($urandom_range(0, 99) < 25);
      sample();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
